// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and read initiator for a 1-cycle registered instruction BRAM,
// presenting {pc, instruction} to decode over valid/ready. Optional counters under FETCH_PERF_EN.
`default_nettype none

module instr_fetch_unit #(
  parameter int                  ADDR_WIDTH = 10,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_rd_n,
  output logic                  imem_wr_n,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  misalign_err,
  output logic [31:0]           perf_fetch,
  output logic [31:0]           perf_stall
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic                resp_valid_q, resp_valid_d;
  logic [1:0]          state_q, state_d;
  logic                misalign_q;

  logic                issue;
  logic [PC_WIDTH-1:0] target_pc;
  logic [PC_WIDTH-1:0] issue_pc;

  assign target_pc = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign issue_pc  = redirect ? target_pc : fetch_pc_q;
  // rst gates the strobe combinationally so no read leaves while reset is held
  assign issue     = ~rst & en & (~resp_valid_q | inst_ready | redirect);

  assign imem_addr    = issue_pc[ADDR_WIDTH+1:2];
  assign imem_rd_n    = ~issue;
  assign imem_wr_n    = 1'b1;
  assign inst_out     = imem_data;
  assign pc_out       = resp_pc_q;
  assign inst_valid   = resp_valid_q & ~redirect;
  assign misalign_err = misalign_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    if (issue) begin
      resp_pc_d    = issue_pc;
      resp_valid_d = 1'b1;
      fetch_pc_d   = issue_pc + PC_WIDTH'(4);
    end else if (redirect) begin
      fetch_pc_d   = target_pc;
      resp_valid_d = 1'b0;
    end else if (resp_valid_q && inst_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (!en && !resp_valid_d)          state_d = S_IDLE;
        else if (inst_valid && !inst_ready) state_d = S_STALL;
      end
      S_STALL: begin
        if (inst_ready || redirect) state_d = (!en && !resp_valid_d) ? S_IDLE : S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= '0;
      resp_valid_q <= 1'b0;
      state_q      <= S_IDLE;
      misalign_q   <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      state_q      <= state_d;
      misalign_q   <= redirect & (|redirect_pc[1:0]);
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (inst_valid && inst_ready)  perf_fetch_q <= perf_fetch_q + 32'd1;
      if (inst_valid && !inst_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_fetch = '0;
  assign perf_stall = '0;
`endif

endmodule

`default_nettype wire
